apb_master: RTL and testbench

APB initiator that converts single-beat requests from an on-chip client into APB transfers on PCLK. It is the bus-side counterpart of the APB peripherals in this design, driving PADDR/PSELx/PENABLE/PWRITE/PWDATA and returning PRDATA to the client. It supports PREADY wait states; peripherals without PREADY tie it high. A timeout aborts transfers to peripherals that never respond.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_master.sv | 168 ++++++++++++++++
 tb/tb_apb_master.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB initiator: bus widths, FSM state encoding
// and the default abort limit for unresponsive peripherals.
package apb_pkg;

    localparam int APB_AW      = 32;
    localparam int APB_DW      = 32;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_master.sv
// APB initiator: turns single-beat client requests into SETUP/ACCESS transfers,
// honours PREADY wait states and aborts with an error after TIMEOUT waits.
module apb_master
    import apb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)
(
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [APB_AW-1:0] cmd_addr,
    input  logic [APB_DW-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [APB_DW-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [APB_AW-1:0] PADDR,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [APB_DW-1:0] PWDATA,
    input  logic [APB_DW-1:0] PRDATA,
    input  logic              PREADY
);

    // A zero TIMEOUT still needs a one-bit counter so the vector is legal.
    localparam int            CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit            TO_EN     = (TIMEOUT > 0);
    localparam logic [CW-1:0] LAST_WAIT = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    apb_state_e        r_state;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [APB_DW-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic [APB_AW-1:0] r_paddr;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [APB_DW-1:0] r_pwdata;
    logic [CW-1:0]     r_wait;

    apb_state_e        w_state_nxt;
    logic              w_cmd_ready_nxt;
    logic              w_rsp_valid_nxt;
    logic [APB_DW-1:0] w_rsp_rdata_nxt;
    logic              w_rsp_err_nxt;
    logic [APB_AW-1:0] w_paddr_nxt;
    logic              w_psel_nxt;
    logic              w_penable_nxt;
    logic              w_pwrite_nxt;
    logic [APB_DW-1:0] w_pwdata_nxt;
    logic [CW-1:0]     w_wait_nxt;

    // Next-state and next-output decode; every output is produced from a register.
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_ready_nxt = r_cmd_ready;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_paddr_nxt     = r_paddr;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_pwdata_nxt    = r_pwdata;
        w_wait_nxt      = r_wait;

        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt     = SETUP;
                    w_cmd_ready_nxt = 1'b0;
                    w_psel_nxt      = 1'b1;
                    w_penable_nxt   = 1'b0;
                    w_paddr_nxt     = cmd_addr;
                    w_pwrite_nxt    = cmd_write;
                    w_pwdata_nxt    = cmd_wdata;
                    w_wait_nxt      = '0;
                end else begin
                    w_cmd_ready_nxt = 1'b1;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                end
            end

            SETUP: begin
                w_state_nxt   = ACCESS;
                w_penable_nxt = 1'b1;
            end

            ACCESS: begin
                // PREADY wins over an expiring counter in the same cycle.
                if (PREADY) begin
                    w_state_nxt     = IDLE;
                    w_cmd_ready_nxt = 1'b1;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_pwrite ? {APB_DW{1'b0}} : PRDATA;
                    w_rsp_err_nxt   = 1'b0;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                end else if (TO_EN && (r_wait == LAST_WAIT)) begin
                    w_state_nxt     = IDLE;
                    w_cmd_ready_nxt = 1'b1;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = {APB_DW{1'b0}};
                    w_rsp_err_nxt   = 1'b1;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                end else if (r_wait != CNT_MAX) begin
                    w_wait_nxt = r_wait + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    w_wait_nxt = r_wait;
                end
            end

            default: begin
                w_state_nxt     = IDLE;
                w_cmd_ready_nxt = 1'b1;
                w_psel_nxt      = 1'b0;
                w_penable_nxt   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears the bus strobes immediately.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {APB_DW{1'b0}};
            r_rsp_err   <= 1'b0;
            r_paddr     <= {APB_AW{1'b0}};
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= {APB_DW{1'b0}};
            r_wait      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_paddr     <= w_paddr_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_wait      <= w_wait_nxt;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign PADDR     = r_paddr;
    assign PSELx     = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed vector table with hand-written
// expectations, an asynchronous reset sequence, and randomized transfers
// checked against a transaction-level latency/response model.
module tb_apb_master;
    import apb_pkg::*;

    localparam int TO = 4;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] PADDR;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    int  n_checks = 0;
    int  n_fail   = 0;
    time prev_acc_t;
    bit  prev_b2b = 1'b0;
    int  prev_cyc = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          nwait;
        logic [31:0] prdata;
        logic        b2b;
        int          exp_cyc;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vq[$];

    apb_master #(.TIMEOUT(TO)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    function automatic vec_t mk(input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input int nwait,
                                input logic [31:0] prdata, input logic b2b,
                                input int exp_cyc, input logic [31:0] exp_rdata,
                                input logic exp_err);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.nwait = nwait;
        v.prdata = prdata; v.b2b = b2b; v.exp_cyc = exp_cyc;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    // Transaction-level model: response cycle counted from the accept edge.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.nwait >= TO) begin
            r.exp_cyc   = 2 + TO;
            r.exp_rdata = 32'h0;
            r.exp_err   = 1'b1;
        end else begin
            r.exp_cyc   = 3 + v.nwait;
            r.exp_rdata = v.wr ? 32'h0 : v.prdata;
            r.exp_err   = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 32'd1);
        chk({tag, "_rsp_valid"}, rsp_valid, 32'd0);
        chk({tag, "_rsp_err"},   rsp_err,   32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_psel"},      PSELx,     32'd0);
        chk({tag, "_penable"},   PENABLE,   32'd0);
        chk({tag, "_pwrite"},    PWRITE,    32'd0);
        chk({tag, "_paddr"},     PADDR,     32'd0);
        chk({tag, "_pwdata"},    PWDATA,    32'd0);
    endtask

    task automatic idle_cycles(input int n, input logic [31:0] held_addr);
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK);
            #1;
            chk("idle_psel",      PSELx,     32'd0);
            chk("idle_penable",   PENABLE,   32'd0);
            chk("idle_rsp_valid", rsp_valid, 32'd0);
            chk("idle_cmd_ready", cmd_ready, 32'd1);
            chk("idle_paddr",     PADDR,     held_addr);
        end
    endtask

    // Called one time unit after a rising edge; returns in the response cycle.
    task automatic run_txn(input vec_t v, input bit has_next, input vec_t nx);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        @(posedge PCLK);
        if (prev_b2b) begin
            chk("accept_spacing", 32'(($time - prev_acc_t) / 10), 32'(prev_cyc));
        end else begin
            n_checks = n_checks;
        end
        prev_acc_t = $time;
        for (int k = 1; k <= v.exp_cyc; k++) begin
            #1;
            if (k == 1) begin
                if (has_next) begin
                    cmd_valid = 1'b1;
                    cmd_write = nx.wr;
                    cmd_addr  = nx.addr;
                    cmd_wdata = nx.wdata;
                end else begin
                    cmd_valid = 1'b0;
                    cmd_write = 1'($urandom_range(0, 1));
                    cmd_addr  = $urandom;
                    cmd_wdata = $urandom;
                end
            end
            chk("psel",      PSELx,     32'(k < v.exp_cyc));
            chk("penable",   PENABLE,   32'((k >= 2) && (k < v.exp_cyc)));
            chk("rsp_valid", rsp_valid, 32'(k == v.exp_cyc));
            chk("cmd_ready", cmd_ready, 32'(k == v.exp_cyc));
            chk("paddr",     PADDR,     v.addr);
            chk("pwrite",    PWRITE,    32'(v.wr));
            chk("pwdata",    PWDATA,    v.wdata);
            if (k == v.exp_cyc) begin
                chk("rsp_rdata", rsp_rdata, v.exp_rdata);
                chk("rsp_err",   rsp_err,   32'(v.exp_err));
            end
            if ((k >= 2) && (k < v.exp_cyc)) begin
                PREADY = ((k - 2) == v.nwait);
            end else begin
                PREADY = 1'($urandom_range(0, 1));
            end
            PRDATA = PREADY ? v.prdata : $urandom;
            if (k < v.exp_cyc) begin
                @(posedge PCLK);
            end
        end
        prev_b2b = has_next;
        prev_cyc = v.exp_cyc;
    endtask

    task automatic run_queue();
        for (int i = 0; i < vq.size(); i++) begin
            bit hn;
            hn = vq[i].b2b && (i + 1 < vq.size());
            run_txn(vq[i], hn, hn ? vq[i + 1] : vq[i]);
            if (!hn) begin
                idle_cycles($urandom_range(0, 2), vq[i].addr);
            end
        end
        vq.delete();
    endtask

    initial begin
        vec_t v;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        PREADY    = 1'b0;
        PRDATA    = 32'h0;

        #7;
        chk_reset("reset");
        #5 PRESETn = 1'b1;
        @(posedge PCLK);
        #1;
        chk_reset("post_reset");

        //          wr    addr          wdata         nw prdata        b2b  cyc rdata         err
        vq.push_back(mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'hA5A5_A5A5, 1'b0, 3, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, 32'h0000_0020, 32'h1111_1111, 2, 32'h1234_5678, 1'b0, 5, 32'h1234_5678, 1'b0));
        vq.push_back(mk(1'b0, 32'h0000_0030, 32'h0,         5, 32'h55AA_55AA, 1'b0, 6, 32'h0,         1'b1));
        vq.push_back(mk(1'b0, 32'h0000_0040, 32'h0,         3, 32'hCAFE_F00D, 1'b0, 6, 32'hCAFE_F00D, 1'b0));
        vq.push_back(mk(1'b1, 32'h0000_0050, 32'h0BAD_F00D, 4, 32'h7777_7777, 1'b0, 6, 32'h0,         1'b1));
        vq.push_back(mk(1'b0, 32'h0000_0060, 32'h0,         0, 32'hFFFF_FFFF, 1'b0, 3, 32'hFFFF_FFFF, 1'b0));
        vq.push_back(mk(1'b1, 32'h0000_0070, 32'h0000_0001, 0, 32'h0,         1'b1, 3, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, 32'h0000_0074, 32'h0,         0, 32'h8765_4321, 1'b1, 3, 32'h8765_4321, 1'b0));
        vq.push_back(mk(1'b1, 32'h0000_0078, 32'h0000_0003, 1, 32'h0,         1'b0, 4, 32'h0,         1'b0));
        run_queue();

        // Reset in the middle of a waited read.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0200;
        cmd_wdata = 32'h0;
        PREADY    = 1'b0;
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        @(posedge PCLK);
        #1;
        @(posedge PCLK);
        #1;
        chk("pre_rst_psel",    PSELx,   32'd1);
        chk("pre_rst_penable", PENABLE, 32'd1);
        #2 PRESETn = 1'b0;
        #1 chk_reset("async_rst");
        @(posedge PCLK);
        #4 PRESETn = 1'b1;
        prev_b2b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge PCLK);
            #1;
            chk("rst_no_rsp",       rsp_valid, 32'd0);
            chk("rst_psel",         PSELx,     32'd0);
            chk("rst_cmd_ready",    cmd_ready, 32'd1);
            chk("rst_paddr",        PADDR,     32'd0);
        end
        vq.push_back(mk(1'b0, 32'h0000_0100, 32'h0, 1, 32'h0F0F_0F0F, 1'b0, 4, 32'h0F0F_0F0F, 1'b0));
        run_queue();

        for (int i = 0; i < 40; i++) begin
            v.wr     = 1'($urandom_range(0, 1));
            v.addr   = $urandom;
            v.wdata  = $urandom;
            v.nwait  = $urandom_range(0, TO + 2);
            v.prdata = $urandom;
            v.b2b    = 1'($urandom_range(0, 1));
            vq.push_back(model(v));
        end
        run_queue();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
